rvvi_trace_gen: RTL and testbench
=================================

RVVI_TRACE_GEN -- requirements
Module: rvvi_trace_gen

Interface
REQ-001 Parameter XLEN, default 64, width of PC field.
REQ-002 Parameter ILEN, default 32, width of instruction field.
REQ-003 Parameter DEPTH, default 4, retire-record FIFO entries (power of 2, >=2).
REQ-004 clk  input  1  single clock for the whole block; all state changes on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 ret_valid  input  1  core offers a retired-instruction record.
REQ-007 ret_ready  output  1  block accepts the record this cycle.
REQ-008 ret_insn  input  ILEN  raw retired instruction bits.
REQ-009 ret_pc  input  XLEN  PC of retired instruction.
REQ-010 ret_trap  input  1  instruction trapped instead of retiring.
REQ-011 trace_en  input  1  1 = emit trace; 0 = pause output, hold FIFO.
REQ-012 flush  input  1  one-cycle request to discard all buffered records.
REQ-013 rvvi_valid  output  1  trace record valid this cycle (hart 0, retire slot 0).
REQ-014 rvvi_insn  output  ILEN  trimmed instruction.
REQ-015 rvvi_pc  output  XLEN  PC of emitted record.
REQ-016 rvvi_trap  output  1  trap flag of emitted record.
REQ-017 rvvi_compressed  output  1  emitted instruction is 16-bit.
REQ-018 rvvi_order  output  64  running count of emitted records.
REQ-019 fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-020 Handshake: a record is pushed on a rising edge where ret_valid && ret_ready; ret_valid/data are not required to hold when ret_ready=0 is not asserted.
REQ-021 ret_ready = (fifo_count < DEPTH) && state != FLUSH, combinational from registered state only.
REQ-022 Push while full is impossible by REQ-021; no push and pop in the same cycle is required to be excluded: when not full, simultaneous push and pop leaves fifo_count unchanged.
REQ-023 FSM states RUN, PAUSE, FLUSH; reset state RUN.
REQ-024 Transitions: any state, flush=1 -> FLUSH; FLUSH -> RUN if trace_en=1 else PAUSE; RUN, trace_en=0 -> PAUSE; PAUSE, trace_en=1 -> RUN; flush has priority over trace_en.
REQ-025 In RUN with fifo_count>0: pop one record per cycle; outputs registered, so rvvi_valid=1 the cycle after the pop edge.
REQ-026 Latency: record pushed at edge N into empty FIFO in RUN appears with rvvi_valid=1 after edge N+1; sustained throughput one record per clock.
REQ-027 In PAUSE or FLUSH, or RUN with empty FIFO, rvvi_valid=0 next cycle; rvvi_insn/pc/trap/compressed hold last values.
REQ-028 FLUSH: at the entering edge FIFO pointers and fifo_count clear to 0; a record offered on the flush cycle is dropped; rvvi_order unchanged.
REQ-029 Compression: if popped insn[1:0] != 2'b11, rvvi_insn = {zeros, insn[15:0]}, rvvi_compressed=1; else rvvi_insn = insn, rvvi_compressed=0.
REQ-030 rvvi_order increments by 1 on every emitted record (trap or not); first emitted record carries order 1; wraps modulo 2^64.
REQ-031 Records emit in strict push order; FIFO pointers wrap modulo DEPTH.

Reset
REQ-032 reset_n=0 asynchronously forces: state RUN, FIFO empty, fifo_count=0, rvvi_valid=0, rvvi_insn=0, rvvi_pc=0, rvvi_trap=0, rvvi_compressed=0, rvvi_order=0.
REQ-033 Reset mid-stream discards all buffered records; ret_ready=1 from the first cycle after reset_n rises.

Verification
REQ-034 Push insn 0x00A00093, pc 0x80000000, trap=0 at edge 1 -> after edge 2 rvvi_valid=1, rvvi_insn=0x00A00093, rvvi_compressed=0, rvvi_order=1.
REQ-035 Push insn 0xDEAD4501 -> emitted rvvi_insn=0x00004501, rvvi_compressed=1.
REQ-036 trace_en=0, push 5 records at DEPTH=4 -> fifo_count=4, ret_ready=0, rvvi_valid=0; trace_en=1 -> 4 back-to-back valids, orders consecutive, push order preserved.
REQ-037 FIFO holding 3 records, pulse flush with ret_valid=1 -> fifo_count=0 next cycle, no rvvi_valid for dropped records, rvvi_order unchanged.
REQ-038 Trapped record (ret_trap=1) -> rvvi_trap=1, rvvi_order still increments.
REQ-039 reset_n low mid-burst with 2 records queued -> all outputs zero immediately, no queued record emitted after release.

Source files
------------

// File: rtl/rvvi_trace_gen_if.sv
// rvvi_trace_gen_if
//   Bundles the retire-side handshake, the trace controls and the RVVI-style
//   trace output of rvvi_trace_gen into one interface.
//
//   Signals
//     ret_valid / ret_ready    retire record handshake (core -> trace block)
//     ret_insn / ret_pc        retired instruction bits and its PC
//     ret_trap                 record is a trap rather than a normal retire
//     trace_en                 1 = emit trace, 0 = hold buffered records
//     flush                    single-cycle request to drop buffered records
//     rvvi_valid               emitted trace record valid (hart 0, slot 0)
//     rvvi_insn / rvvi_pc      emitted instruction (trimmed) and its PC
//     rvvi_trap                trap flag of emitted record
//     rvvi_compressed          emitted instruction is a 16-bit encoding
//     rvvi_order               running count of emitted records
//     fifo_count               current buffer occupancy
//
//   Modports
//     master  the retiring core / environment side
//     slave   the trace generator itself
interface rvvi_trace_gen_if #(
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             ret_valid;
    logic             ret_ready;
    logic [ILEN-1:0]  ret_insn;
    logic [XLEN-1:0]  ret_pc;
    logic             ret_trap;
    logic             trace_en;
    logic             flush;
    logic             rvvi_valid;
    logic [ILEN-1:0]  rvvi_insn;
    logic [XLEN-1:0]  rvvi_pc;
    logic             rvvi_trap;
    logic             rvvi_compressed;
    logic [63:0]      rvvi_order;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        output ret_valid, ret_insn, ret_pc, ret_trap, trace_en, flush,
        input  ret_ready, rvvi_valid, rvvi_insn, rvvi_pc, rvvi_trap,
               rvvi_compressed, rvvi_order, fifo_count
    );

    modport slave (
        input  ret_valid, ret_insn, ret_pc, ret_trap, trace_en, flush,
        output ret_ready, rvvi_valid, rvvi_insn, rvvi_pc, rvvi_trap,
               rvvi_compressed, rvvi_order, fifo_count
    );
endinterface

// File: rtl/rvvi_trace_gen.sv
// rvvi_trace_gen
//   Buffers retired-instruction records from the core in a small FIFO and
//   emits them one per clock as registered RVVI-style trace records. Emission
//   can be paused (trace_en=0) without losing buffered records, and a flush
//   drops everything buffered.
//
//   Ports
//     clk      single clock, all state changes on the rising edge
//     reset_n  asynchronous active-low reset
//     bus      rvvi_trace_gen_if.slave: retire handshake in, trace record out
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | emitting: pop one buffered record per clock when available
//   PAUSE | trace disabled: buffer holds, accepts pushes while not full
//   FLUSH | one cycle after a flush: buffer empty, ret_ready held low
module rvvi_trace_gen #(
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    rvvi_trace_gen_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [ILEN-1:0]  mem_insn_q [DEPTH];
    logic [XLEN-1:0]  mem_pc_q   [DEPTH];
    logic             mem_trap_q [DEPTH];

    logic             valid_q, valid_d;
    logic [ILEN-1:0]  insn_q, insn_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             trap_q, trap_d;
    logic             comp_q, comp_d;
    logic [63:0]      order_q, order_d;

    logic             ready;
    logic             push;
    logic             pop;
    logic [ILEN-1:0]  head_insn;
    logic             head_comp;

    // Ready depends only on registered state so it never loops back through
    // the core's valid logic.
    assign ready = (count_q < DEPTH_CNT) && (state_q != FLUSH);

    // A flush wins over everything: the record offered alongside it is not
    // stored, and the head record is not emitted either.
    assign push = bus.ret_valid && ready && !bus.flush;
    assign pop  = (state_q == RUN) && (count_q != '0) && !bus.flush;

    assign head_insn = mem_insn_q[rd_ptr_q];
    assign head_comp = (head_insn[1:0] != 2'b11);

    // FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                RUN:     if (!bus.trace_en) state_d = PAUSE;
                PAUSE:   if (bus.trace_en)  state_d = RUN;
                FLUSH:   state_d = bus.trace_en ? RUN : PAUSE;
                default: state_d = RUN;
            endcase
        end
    end

    // FIFO pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_insn_q[wr_ptr_q] <= bus.ret_insn;
            mem_pc_q[wr_ptr_q]   <= bus.ret_pc;
            mem_trap_q[wr_ptr_q] <= bus.ret_trap;
        end
    end

    // Output record register; fields hold their last value when idle.
    always_comb begin
        valid_d = pop;
        insn_d  = insn_q;
        pc_d    = pc_q;
        trap_d  = trap_q;
        comp_d  = comp_q;
        order_d = order_q;
        if (pop) begin
            insn_d  = head_comp ? {{(ILEN-16){1'b0}}, head_insn[15:0]} : head_insn;
            pc_d    = mem_pc_q[rd_ptr_q];
            trap_d  = mem_trap_q[rd_ptr_q];
            comp_d  = head_comp;
            order_d = order_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            insn_q  <= '0;
            pc_q    <= '0;
            trap_q  <= 1'b0;
            comp_q  <= 1'b0;
            order_q <= '0;
        end else begin
            valid_q <= valid_d;
            insn_q  <= insn_d;
            pc_q    <= pc_d;
            trap_q  <= trap_d;
            comp_q  <= comp_d;
            order_q <= order_d;
        end
    end

    assign bus.ret_ready       = ready;
    assign bus.rvvi_valid      = valid_q;
    assign bus.rvvi_insn       = insn_q;
    assign bus.rvvi_pc         = pc_q;
    assign bus.rvvi_trap       = trap_q;
    assign bus.rvvi_compressed = comp_q;
    assign bus.rvvi_order      = order_q;
    assign bus.fifo_count      = count_q;

endmodule

// File: tb/tb_rvvi_trace_gen.sv
// tb_rvvi_trace_gen
//   Self-checking bench for rvvi_trace_gen: directed scenarios followed by
//   randomized traffic, all compared against a queue-based reference model.
module tb_rvvi_trace_gen;
    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int DEPTH = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    rvvi_trace_gen_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) bus ();

    rvvi_trace_gen #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [ILEN-1:0] insn;
        logic [XLEN-1:0] pc;
        logic            trap;
    } rec_t;

    typedef enum {M_RUN, M_PAUSE, M_FLUSH} mode_t;

    rec_t            mq[$];
    mode_t           mode;
    logic            exp_valid;
    logic [ILEN-1:0] exp_insn;
    logic [XLEN-1:0] exp_pc;
    logic            exp_trap;
    logic            exp_comp;
    logic [63:0]     exp_order;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mode      = M_RUN;
        exp_valid = 1'b0;
        exp_insn  = '0;
        exp_pc    = '0;
        exp_trap  = 1'b0;
        exp_comp  = 1'b0;
        exp_order = '0;
    endtask

    task automatic check_outputs();
        chk("rvvi_valid",      64'(bus.rvvi_valid),      64'(exp_valid));
        chk("rvvi_insn",       64'(bus.rvvi_insn),       64'(exp_insn));
        chk("rvvi_pc",         64'(bus.rvvi_pc),         64'(exp_pc));
        chk("rvvi_trap",       64'(bus.rvvi_trap),       64'(exp_trap));
        chk("rvvi_compressed", 64'(bus.rvvi_compressed), 64'(exp_comp));
        chk("rvvi_order",      bus.rvvi_order,           exp_order);
        chk("fifo_count",      64'(bus.fifo_count),      64'(mq.size()));
    endtask

    // One clock: drive inputs, check ready, take the edge, advance the model,
    // then compare every output.
    task automatic cycle(input logic v, input logic [ILEN-1:0] ins,
                         input logic [XLEN-1:0] pc, input logic trap,
                         input logic en, input logic fl);
        rec_t head;
        rec_t nrec;
        logic mdl_ready;
        bus.ret_valid = v;
        bus.ret_insn  = ins;
        bus.ret_pc    = pc;
        bus.ret_trap  = trap;
        bus.trace_en  = en;
        bus.flush     = fl;
        mdl_ready = (mq.size() < DEPTH) && (mode != M_FLUSH);
        chk("ret_ready", 64'(bus.ret_ready), 64'(mdl_ready));
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        if (fl) begin
            mq.delete();
        end else begin
            if (mode == M_RUN && mq.size() > 0) begin
                head      = mq.pop_front();
                exp_valid = 1'b1;
                exp_pc    = head.pc;
                exp_trap  = head.trap;
                exp_comp  = (head.insn[1:0] != 2'b11);
                exp_insn  = exp_comp ? {16'h0000, head.insn[15:0]} : head.insn;
                exp_order = exp_order + 64'd1;
            end
            if (v && mdl_ready) begin
                nrec.insn = ins;
                nrec.pc   = pc;
                nrec.trap = trap;
                mq.push_back(nrec);
            end
        end
        mode = fl ? M_FLUSH : (en ? M_RUN : M_PAUSE);
        check_outputs();
    endtask

    task automatic idle(input logic en, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, en, 1'b0);
    endtask

    initial begin
        bus.ret_valid = 1'b0;
        bus.ret_insn  = '0;
        bus.ret_pc    = '0;
        bus.ret_trap  = 1'b0;
        bus.trace_en  = 1'b1;
        bus.flush     = 1'b0;
        model_reset();
        #2 reset_n = 1'b0;
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;

        // Normal 32-bit instruction: visible after the second edge.
        cycle(1'b1, 32'h00A00093, 64'h80000000, 1'b0, 1'b1, 1'b0);
        chk("r034_valid_early", 64'(bus.rvvi_valid), 64'd0);
        idle(1'b1, 1);
        chk("r034_valid", 64'(bus.rvvi_valid), 64'd1);
        chk("r034_insn",  64'(bus.rvvi_insn),  64'h00A00093);
        chk("r034_comp",  64'(bus.rvvi_compressed), 64'd0);
        chk("r034_order", bus.rvvi_order, 64'd1);

        // Compressed instruction gets trimmed to 16 bits.
        cycle(1'b1, 32'hDEAD4501, 64'h80000004, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 1);
        chk("r035_insn", 64'(bus.rvvi_insn), 64'h00004501);
        chk("r035_comp", 64'(bus.rvvi_compressed), 64'd1);
        idle(1'b1, 1);

        // Pause, overfill, then drain back-to-back.
        idle(1'b0, 1);
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 32'h00000013 + 32'(i << 20), 64'h1000 + 64'(4 * i), 1'b0, 1'b0, 1'b0);
        chk("r036_count", 64'(bus.fifo_count), 64'd4);
        chk("r036_ready", 64'(bus.ret_ready), 64'd0);
        chk("r036_valid", 64'(bus.rvvi_valid), 64'd0);
        idle(1'b1, 2);
        chk("r036_first_pc", bus.rvvi_pc, 64'h1000);
        idle(1'b1, 4);

        // Flush with three queued and a record offered in the same cycle.
        idle(1'b0, 1);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h00100093 + 32'(i), 64'h2000 + 64'(4 * i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200093, 64'h3000, 1'b0, 1'b0, 1'b1);
        chk("r037_count", 64'(bus.fifo_count), 64'd0);
        idle(1'b1, 4);
        chk("r037_order", bus.rvvi_order, 64'd6);

        // Trapped record still counts toward the order.
        cycle(1'b1, 32'h00000073, 64'h4000, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 1);
        chk("r038_trap",  64'(bus.rvvi_trap), 64'd1);
        chk("r038_order", bus.rvvi_order, 64'd7);
        idle(1'b1, 1);

        // Reset mid-burst with two records queued.
        idle(1'b0, 1);
        cycle(1'b1, 32'h00500093, 64'h5000, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h00600093, 64'h5004, 1'b0, 1'b1, 1'b0);
        bus.ret_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #3 reset_n = 1'b1;
        idle(1'b1, 4);

        // Randomized traffic with occasional pauses and flushes.
        begin
            logic en;
            logic [ILEN-1:0] ins;
            en = 1'b1;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 15) == 0) en = ~en;
                ins = $urandom();
                if ($urandom_range(0, 1) == 1) ins[1:0] = 2'b11;
                cycle(1'($urandom_range(0, 1)), ins, {$urandom(), $urandom()},
                      ($urandom_range(0, 9) == 0), en,
                      ($urandom_range(0, 39) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
